// File: rtl/ahb3lite_cmd_master.sv
// Single-outstanding AHB3-lite initiator: valid/ready commands in, single
// transfers on the bus, one in-order response per command.
module ahb3lite_cmd_master #(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [1:0]  cmd_size_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] haddr_o,
  output logic        hwrite_o,
  output logic [2:0]  hsize_o,
  output logic [2:0]  hburst_o,
  output logic [3:0]  hprot_o,
  output logic [1:0]  htrans_o,
  output logic        hmastlock_o,
  output logic [31:0] hwdata_o,
  input  logic [31:0] hrdata_i,
  input  logic        hready_i,
  input  logic        hresp_i
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic {ST_NORMAL, ST_CANCEL} state_e;

  state_e      state_q, state_d;

  logic        ap_vld_q, ap_vld_d;
  logic        ap_wr_q, ap_wr_d;
  logic [31:0] ap_addr_q, ap_addr_d;
  logic [1:0]  ap_size_q, ap_size_d;
  logic [31:0] ap_wdata_q, ap_wdata_d;
  logic        ap_rej_q, ap_rej_d;

  logic        dp_vld_q, dp_vld_d;
  logic        dp_wr_q, dp_wr_d;
  logic [31:0] dp_wdata_q, dp_wdata_d;
  logic        dp_rej_q, dp_rej_d;

  logic        rsp_vld_q, rsp_vld_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        cancel;
  logic        cmd_acc;
  logic        cmd_rej;

  assign cancel  = (state_q == ST_CANCEL);
  assign cmd_acc = cmd_valid_i & cmd_ready_o;

  // Misaligned or reserved-size commands never reach the bus but still
  // travel through both stages so their error response stays in order.
  assign cmd_rej = (cmd_size_i == 2'b11) ||
                   ((cmd_size_i == 2'b01) && cmd_addr_i[0]) ||
                   ((cmd_size_i == 2'b10) && (cmd_addr_i[1:0] != 2'b00));

  assign cmd_ready_o = ~rst_i & ~cancel & (~ap_vld_q | hready_i);

  assign htrans_o    = (ap_vld_q & ~ap_rej_q & ~cancel) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr_o     = ap_addr_q;
  assign hwrite_o    = ap_wr_q;
  assign hsize_o     = {1'b0, ap_size_q};
  assign hburst_o    = 3'b000;
  assign hprot_o     = HPROT_VAL;
  assign hmastlock_o = 1'b0;
  assign hwdata_o    = dp_wdata_q;

  assign rsp_valid_o = rsp_vld_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

  always_comb begin
    state_d     = state_q;
    ap_vld_d    = ap_vld_q;
    ap_wr_d     = ap_wr_q;
    ap_addr_d   = ap_addr_q;
    ap_size_d   = ap_size_q;
    ap_wdata_d  = ap_wdata_q;
    ap_rej_d    = ap_rej_q;
    dp_vld_d    = dp_vld_q;
    dp_wr_d     = dp_wr_q;
    dp_wdata_d  = dp_wdata_q;
    dp_rej_d    = dp_rej_q;
    rsp_vld_d   = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;

    case (state_q)
      ST_NORMAL: begin
        if (hready_i) begin
          if (dp_vld_q) begin
            rsp_vld_d   = 1'b1;
            rsp_err_d   = dp_rej_q | hresp_i;
            rsp_rdata_d = (dp_wr_q | dp_rej_q | hresp_i) ? 32'h0 : hrdata_i;
          end
          dp_vld_d   = ap_vld_q;
          dp_wr_d    = ap_wr_q;
          dp_wdata_d = ap_wdata_q;
          dp_rej_d   = ap_rej_q;
          ap_vld_d   = 1'b0;
        end else if (dp_vld_q && hresp_i) begin
          state_d = ST_CANCEL;
        end
      end
      ST_CANCEL: begin
        // AP is left untouched so the cancelled transfer is replayed next cycle.
        if (hready_i) begin
          rsp_vld_d = 1'b1;
          rsp_err_d = 1'b1;
          dp_vld_d  = 1'b0;
          state_d   = ST_NORMAL;
        end
      end
      default: state_d = ST_NORMAL;
    endcase

    if (cmd_acc) begin
      ap_vld_d   = 1'b1;
      ap_wr_d    = cmd_write_i;
      ap_addr_d  = cmd_addr_i;
      ap_size_d  = cmd_size_i;
      ap_wdata_d = cmd_wdata_i;
      ap_rej_d   = cmd_rej;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_NORMAL;
      ap_vld_q    <= 1'b0;
      ap_wr_q     <= 1'b0;
      ap_addr_q   <= 32'h0;
      ap_size_q   <= 2'b00;
      ap_wdata_q  <= 32'h0;
      ap_rej_q    <= 1'b0;
      dp_vld_q    <= 1'b0;
      dp_wr_q     <= 1'b0;
      dp_wdata_q  <= 32'h0;
      dp_rej_q    <= 1'b0;
      rsp_vld_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ap_vld_q    <= ap_vld_d;
      ap_wr_q     <= ap_wr_d;
      ap_addr_q   <= ap_addr_d;
      ap_size_q   <= ap_size_d;
      ap_wdata_q  <= ap_wdata_d;
      ap_rej_q    <= ap_rej_d;
      dp_vld_q    <= dp_vld_d;
      dp_wr_q     <= dp_wr_d;
      dp_wdata_q  <= dp_wdata_d;
      dp_rej_q    <= dp_rej_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_ahb3lite_cmd_master.sv
// Bench for ahb3lite_cmd_master: AHB slave model with wait/error injection,
// in-order response scoreboard fed by a memory-level reference model.
module tb_ahb3lite_cmd_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [1:0]  cmd_size = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] haddr, hwdata, hrdata;
  logic        hwrite, hmastlock, hready, hresp;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;

  always #5 clk = ~clk;

  ahb3lite_cmd_master dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_size_i(cmd_size), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .haddr_o(haddr), .hwrite_o(hwrite), .hsize_o(hsize), .hburst_o(hburst),
    .hprot_o(hprot), .htrans_o(htrans), .hmastlock_o(hmastlock), .hwdata_o(hwdata),
    .hrdata_i(hrdata), .hready_i(hready), .hresp_i(hresp)
  );

  int n_chk = 0, n_fail = 0, cyc = 0;
  int fixed_waits = 0, max_waits = 0;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic [31:0] smem [0:63];
  logic [31:0] ref_mem [0:63];

  function automatic logic is_err_addr(input logic [31:0] a, input logic [31:0] ea);
    return (a == ea) || (a[7:4] == 4'hF);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] a, input logic [1:0] sz);
    logic [3:0] be;
    logic [31:0] r;
    be = (sz == 2'd0) ? (4'b0001 << a) : (sz == 2'd1) ? (4'b0011 << a) : 4'b1111;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // ---------------- AHB slave model ----------------
  logic        s_act, s_wr, s_err;
  logic [31:0] s_addr;
  logic [1:0]  s_size;
  int          s_left, rnd_waits;
  logic        start, wr_now, n_err, n_wr;
  logic [31:0] n_addr, wr_word, rd_word;
  logic [1:0]  n_size;
  int          n_left;

  always_comb begin
    wr_now  = hready && s_act && s_wr && !s_err;
    wr_word = merge(smem[s_addr[7:2]], hwdata, s_addr[1:0], s_size);
    start   = hready && (htrans == 2'b10);
    if (start) begin
      n_err  = is_err_addr(haddr, err_addr);
      n_wr   = hwrite;
      n_addr = haddr;
      n_size = hsize[1:0];
      n_left = ((fixed_waits >= 0) ? fixed_waits : rnd_waits) + (n_err ? 1 : 0);
    end else begin
      n_err  = s_err;
      n_wr   = s_wr;
      n_addr = s_addr;
      n_size = s_size;
      n_left = s_left - 1;
    end
    rd_word = (wr_now && s_addr[7:2] == n_addr[7:2]) ? wr_word : smem[n_addr[7:2]];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hready <= 1'b1; hresp <= 1'b0; hrdata <= 32'h0;
      s_act <= 1'b0; s_wr <= 1'b0; s_err <= 1'b0; s_addr <= '0; s_size <= '0;
      s_left <= 0; rnd_waits <= 0;
    end else begin
      rnd_waits <= $urandom_range(max_waits, 0);
      if (wr_now) smem[s_addr[7:2]] <= wr_word;
      if (hready && !start) begin
        s_act <= 1'b0; hready <= 1'b1; hresp <= 1'b0; hrdata <= 32'hDEAD_BEEF;
      end else begin
        s_act <= 1'b1; s_err <= n_err; s_wr <= n_wr; s_addr <= n_addr;
        s_size <= n_size; s_left <= n_left;
        if (n_left > 0) begin
          hready <= 1'b0; hresp <= n_err && (n_left == 1); hrdata <= 32'hDEAD_BEEF;
        end else begin
          hready <= 1'b1; hresp <= n_err;
          hrdata <= (n_err || n_wr) ? 32'hDEAD_BEEF : rd_word;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {logic err; logic [31:0] rdata; int acc; int lat;} exp_t;
  exp_t expq[$];

  logic        p_ok = 1'b0, p_hready = 1'b1, p_hresp = 1'b0;
  logic [1:0]  p_htrans = '0;
  logic [31:0] p_haddr = '0;

  always @(negedge clk) begin : chk_b
    exp_t e;
    if (!rst) begin
      if (rsp_valid) begin
        n_chk++;
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: got valid err=%0b rdata=%h, required no response", rsp_err, rsp_rdata);
        end else begin
          e = expq.pop_front();
          if (rsp_err !== e.err || rsp_rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL rsp_data: got err=%0b rdata=%h, required err=%0b rdata=%h", rsp_err, rsp_rdata, e.err, e.rdata);
          end
          if (e.lat >= 0) begin
            n_chk++;
            if (cyc - e.acc != e.lat) begin
              n_fail++;
              $display("FAIL rsp_latency: got %0d, required %0d", cyc - e.acc, e.lat);
            end
          end
        end
      end
      if (p_ok && !p_hready && !p_hresp && p_htrans == 2'b10) begin
        n_chk++;
        if (htrans !== 2'b10 || haddr !== p_haddr) begin
          n_fail++;
          $display("FAIL wait_stable: got htrans=%b haddr=%h, required htrans=10 haddr=%h", htrans, haddr, p_haddr);
        end
      end
    end
    p_ok = !rst; p_hready = hready; p_hresp = hresp; p_htrans = htrans; p_haddr = haddr;
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference model: alignment means address is a multiple of the transfer size.
  task automatic model(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                       input logic [31:0] wd, output logic e, output logic [31:0] rd);
    logic rej;
    rej = (sz == 2'd3) || ((a % (32'd1 << sz)) != 0);
    e = rej || is_err_addr(a, err_addr);
    rd = 32'h0;
    if (!e) begin
      if (wr) ref_mem[a[7:2]] = merge(ref_mem[a[7:2]], wd, a[1:0], sz);
      else    rd = ref_mem[a[7:2]];
    end
  endtask

  // Called on a negedge; returns on the negedge after the accepting edge.
  task automatic send(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                      input logic [31:0] wd, input int lat, input logic use_t,
                      input logic t_err, input logic [31:0] t_rd);
    logic rdy, me, done;
    logic [31:0] mrd;
    exp_t e;
    done = 1'b0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_size = sz; cmd_wdata = wd;
    for (int i = 0; i < 200 && !done; i++) begin
      #1 rdy = cmd_ready;
      @(posedge clk);
      if (rdy) begin
        model(wr, a, sz, wd, me, mrd);
        e.err = use_t ? t_err : me;
        e.rdata = use_t ? t_rd : mrd;
        e.acc = cyc;
        e.lat = lat;
        expq.push_back(e);
        done = 1'b1;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: command at %h not accepted within 200 cycles", a);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && expq.size() > 0; i++) @(negedge clk);
    n_chk++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL rsp_timeout: %0d responses outstanding, required 0", expq.size());
      expq.delete();
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic wr; logic [31:0] a; logic [1:0] sz; logic [31:0] wd;
    logic e; logic [31:0] rd; int lat;
  } vec_t;
  vec_t tbl [15];

  initial begin
    for (int i = 0; i < 64; i++) begin
      smem[i] = 32'h1000_0000 | i;
      ref_mem[i] = 32'h1000_0000 | i;
    end
    tbl[0]  = '{1'b1, 32'h20,  2'd2, 32'h1122_3344, 1'b0, 32'h0,         2};
    tbl[1]  = '{1'b1, 32'h24,  2'd2, 32'hA5A5_A5A5, 1'b0, 32'h0,         2};
    tbl[2]  = '{1'b1, 32'h21,  2'd0, 32'h0000_BB00, 1'b0, 32'h0,         2};
    tbl[3]  = '{1'b0, 32'h20,  2'd2, 32'h0,         1'b0, 32'h1122_BB44, 2};
    tbl[4]  = '{1'b1, 32'h26,  2'd1, 32'h7766_0000, 1'b0, 32'h0,         2};
    tbl[5]  = '{1'b0, 32'h24,  2'd2, 32'h0,         1'b0, 32'h7766_A5A5, 2};
    tbl[6]  = '{1'b0, 32'h102, 2'd2, 32'h0,         1'b1, 32'h0,         2};
    tbl[7]  = '{1'b0, 32'h20,  2'd3, 32'h0,         1'b1, 32'h0,         2};
    tbl[8]  = '{1'b0, 32'h23,  2'd1, 32'h0,         1'b1, 32'h0,         2};
    tbl[9]  = '{1'b1, 32'h2A,  2'd2, 32'hFFFF_FFFF, 1'b1, 32'h0,         2};
    tbl[10] = '{1'b1, 32'h2B,  2'd0, 32'hCC00_0000, 1'b0, 32'h0,         2};
    tbl[11] = '{1'b0, 32'h28,  2'd2, 32'h0,         1'b0, 32'hCC00_000A, 2};
    tbl[12] = '{1'b0, 32'h22,  2'd1, 32'h0,         1'b0, 32'h1122_BB44, 2};
    tbl[13] = '{1'b0, 32'hF0,  2'd2, 32'h0,         1'b1, 32'h0,         3};
    tbl[14] = '{1'b1, 32'hF4,  2'd2, 32'h1234_5678, 1'b1, 32'h0,         3};

    #1 rst = 1'b1;
    #2;
    chk("reset_htrans", {30'h0, htrans}, 32'h0);
    chk("reset_haddr", haddr, 32'h0);
    chk("reset_hwdata", hwdata, 32'h0);
    chk("reset_ctrl", {hwrite, hsize, cmd_ready, rsp_valid, rsp_err}, 32'h0);
    chk("reset_rdata", rsp_rdata, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // table-driven single commands, zero wait states
    fixed_waits = 0;
    for (int i = 0; i < 15; i++) begin
      send(tbl[i].wr, tbl[i].a, tbl[i].sz, tbl[i].wd, tbl[i].lat, 1'b1, tbl[i].e, tbl[i].rd);
      wait_idle();
    end

    // single write, fixed AHB outputs
    send(1'b1, 32'h100, 2'd2, 32'hCAFE_F00D, 2, 1'b1, 1'b0, 32'h0);
    chk("wr_htrans", {30'h0, htrans}, 32'h2);
    chk("wr_haddr", haddr, 32'h100);
    chk("wr_ctrl", {hwrite, hsize, hburst, hprot, hmastlock}, {19'h0, 1'b1, 3'b010, 3'b000, 4'b0011, 1'b0});
    @(negedge clk);
    chk("wr_dphase_htrans", {30'h0, htrans}, 32'h0);
    chk("wr_hwdata", hwdata, 32'hCAFE_F00D);
    wait_idle();

    // read with 2 wait states, second read queued behind it
    smem[12] = 32'h1234_5678; ref_mem[12] = 32'h1234_5678;
    smem[13] = 32'h9ABC_DEF0; ref_mem[13] = 32'h9ABC_DEF0;
    fixed_waits = 2;
    send(1'b0, 32'h30, 2'd2, 32'h0, 4, 1'b1, 1'b0, 32'h1234_5678);
    send(1'b0, 32'h34, 2'd2, 32'h0, 6, 1'b1, 1'b0, 32'h9ABC_DEF0);
    chk("wait_hready", {31'h0, hready}, 32'h0);
    chk("wait_haddr", haddr, 32'h34);
    wait_idle();
    fixed_waits = 0;

    // three back-to-back writes
    send(1'b1, 32'h0, 2'd2, 32'hAAAA_0001, 2, 1'b0, 1'b0, 32'h0);
    chk("b2b_0", {htrans, haddr[29:0]}, {2'b10, 30'h0});
    send(1'b1, 32'h4, 2'd2, 32'hAAAA_0002, 2, 1'b0, 1'b0, 32'h0);
    chk("b2b_1", {htrans, haddr[29:0]}, {2'b10, 30'h4});
    send(1'b1, 32'h8, 2'd2, 32'hAAAA_0003, 2, 1'b0, 1'b0, 32'h0);
    chk("b2b_2", {htrans, haddr[29:0]}, {2'b10, 30'h8});
    wait_idle();

    // ERROR on first of two reads, second is replayed
    err_addr = 32'h10;
    send(1'b0, 32'h10, 2'd2, 32'h0, 3, 1'b1, 1'b1, 32'h0);
    send(1'b0, 32'h14, 2'd2, 32'h0, 4, 1'b1, 1'b0, 32'h1000_0005);
    chk("err_cycle1", {30'h0, hready, hresp}, 32'h1);
    @(negedge clk);
    chk("err_cycle2", {28'h0, hready, hresp, htrans}, 32'hC);
    chk("err_ready", {31'h0, cmd_ready}, 32'h0);
    @(negedge clk);
    chk("err_replay", {htrans, haddr[29:0]}, {2'b10, 30'h14});
    wait_idle();
    err_addr = 32'hFFFF_FFFF;

    // local rejects stay IDLE, a following read completes in order
    send(1'b0, 32'h102, 2'd2, 32'h0, 2, 1'b1, 1'b1, 32'h0);
    chk("rej_idle0", {30'h0, htrans}, 32'h0);
    send(1'b0, 32'h40, 2'd3, 32'h0, 2, 1'b1, 1'b1, 32'h0);
    chk("rej_idle1", {30'h0, htrans}, 32'h0);
    send(1'b0, 32'h24, 2'd2, 32'h0, 2, 1'b1, 1'b0, 32'h7766_A5A5);
    chk("rej_next", {htrans, haddr[29:0]}, {2'b10, 30'h24});
    wait_idle();

    // reset during a wait-stated read
    fixed_waits = 6;
    send(1'b0, 32'h28, 2'd2, 32'h0, -1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_htrans", {30'h0, htrans}, 32'h0);
    chk("rst_mid_haddr", haddr, 32'h0);
    chk("rst_mid_ctrl", {cmd_ready, rsp_valid, rsp_err, hwrite}, 32'h0);
    expq.delete();
    fixed_waits = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send(1'b0, 32'h24, 2'd2, 32'h0, 2, 1'b1, 1'b0, 32'h7766_A5A5);
    wait_idle();

    // randomized traffic against the reference model
    fixed_waits = -1;
    max_waits = 3;
    for (int n = 0; n < 300; n++) begin
      logic wr;
      logic [1:0] sz;
      logic [31:0] a;
      repeat ($urandom_range(2, 0)) @(negedge clk);
      wr = $urandom_range(1, 0);
      sz = ($urandom_range(9, 0) == 0) ? 2'd3 : 2'($urandom_range(2, 0));
      a = $urandom_range(255, 0);
      if (sz != 2'd3 && $urandom_range(3, 0) != 0) a = a & ~((32'd1 << sz) - 1);
      send(wr, a, sz, $urandom, -1, 1'b0, 1'b0, 32'h0);
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
